// File: rtl/parity_serializer_pkg.sv
// -------------------------------------------------------------------------
// parity_serializer_pkg : FSM state encoding, frame constants, parity helper
// Rev 1.0
// -------------------------------------------------------------------------
`default_nettype none

package parity_serializer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int DATA_BITS  = 4;
  localparam int FRAME_BITS = 7;

  // Parity bit the generator should have produced for this nibble.
  function automatic logic expected_parity(input logic [DATA_BITS-1:0] data,
                                           input logic                 odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

`default_nettype wire

// File: rtl/parity_serializer_bit_timer.sv
// -------------------------------------------------------------------------
// bit_timer : bit-period counter; tick marks the last cycle of each period
// Rev 1.0
// -------------------------------------------------------------------------
`default_nettype none

module bit_timer
  import parity_serializer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int               CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign tick = (count_q == LAST);

  // Restarting on clear keeps every new state aligned to a full bit period.
  always_comb begin
    count_d = count_q + 1'b1;
    if (clear || tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/parity_serializer.sv
// -------------------------------------------------------------------------
// parity_serializer : nibble + parity -> start/4 data/parity/stop, LSB first
// Rev 1.0   Optional check logic: PARITY_SERIALIZER_CHECK_EN
// -------------------------------------------------------------------------
`default_nettype none

module parity_serializer
  import parity_serializer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 parity_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 parity_err
);

  state_t               state_q;
  state_t               state_d;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic                 parity_q;
  logic                 parity_d;
  logic [1:0]           bit_idx_q;
  logic [1:0]           bit_idx_d;
  logic                 tick;
  logic                 accept;
  logic                 timer_clear;

  // in_ready is masked by rst so a request during reset is never taken.
  assign in_ready    = (state_q == IDLE) && !rst;
  assign accept      = in_valid && in_ready;
  assign busy        = (state_q != IDLE);
  assign timer_clear = (state_d != state_q);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(timer_clear),
    .tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    bit_idx_d  = bit_idx_q;
    tx         = 1'b1;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d   = data_in;
          parity_d  = parity_in;
          bit_idx_d = '0;
          state_d   = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (tick) begin
          state_d = DATA;
        end
      end
      DATA: begin
        tx = shift_q[0];
        if (tick) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 2'(DATA_BITS - 1)) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        tx = parity_q;
        if (tick) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          frame_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      bit_idx_q <= bit_idx_d;
    end
  end

`ifdef PARITY_SERIALIZER_CHECK_EN
  logic parity_err_q;
  logic parity_err_d;

  // A bad parity is flagged but still transmitted so the link sees the error.
  always_comb begin
    parity_err_d = accept && (parity_in != expected_parity(data_in, PARITY_ODD != 0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
  assign parity_err        = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_parity_serializer.sv
// -------------------------------------------------------------------------
// tb_parity_serializer : directed + randomized frames against a frame model
// Rev 1.0
// -------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_parity_serializer;

  localparam int CLKS         = 4;
  localparam int FRAME_CYCLES = 7 * CLKS;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] data_in;
  logic       parity_in;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic       frame_done;
  logic       parity_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int accept_cyc[$];

  parity_serializer #(
    .CLKS_PER_BIT(CLKS),
    .PARITY_ODD  (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .parity_in (parity_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && in_valid && in_ready) accept_cyc.push_back(cyc);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line levels of one frame, index 0 = start bit, 6 = stop bit.
  function automatic logic [6:0] frame_bits(input logic [3:0] d, input logic p);
    return {1'b1, p, d[3], d[2], d[1], d[0], 1'b0};
  endfunction

  function automatic logic exp_err(input logic [3:0] d, input logic p);
`ifdef PARITY_SERIALIZER_CHECK_EN
    int ones;
    ones = int'(d[0]) + int'(d[1]) + int'(d[2]) + int'(d[3]);
    return p != ((ones % 2) == 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_tx"}, 32'(tx), 32'd1);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(frame_done), 32'd0);
  endtask

  // Called at a negedge; returns at the negedge of the first START cycle.
  task automatic start_frame(input logic [3:0] d, input logic p);
    int n;
    n = 0;
    data_in   = d;
    parity_in = p;
    in_valid  = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(n < 200), 32'd1);
    @(negedge clk);
  endtask

  // Walks all cycles of a frame; returns at the negedge of the last STOP cycle.
  task automatic check_frame(input logic [3:0] d, input logic p, input bit scramble);
    logic [6:0] bits;
    bits = frame_bits(d, p);
    for (int k = 0; k < FRAME_CYCLES; k++) begin
      check("frame_tx", 32'(tx), 32'(bits[k / CLKS]));
      check("frame_busy", 32'(busy), 32'd1);
      check("frame_ready", 32'(in_ready), 32'd0);
      check("frame_done", 32'(frame_done), 32'(k == FRAME_CYCLES - 1));
      check("frame_perr", 32'(parity_err), 32'((k == 0) && exp_err(d, p)));
      if (k < FRAME_CYCLES - 1) begin
        if (scramble) begin
          data_in   = 4'($urandom);
          parity_in = 1'($urandom);
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    logic [3:0] d;
    logic       p;

    // Reset with a pending request
    rst       = 1'b1;
    in_valid  = 1'b1;
    data_in   = 4'($urandom);
    parity_in = 1'($urandom);
    repeat (3) begin
      @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd0);
      check("rst_done", 32'(frame_done), 32'd0);
      check("rst_perr", 32'(parity_err), 32'd0);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_idle("post_rst");
    check("rst_no_accept", 32'(accept_cyc.size()), 32'd0);

    // Directed single frame
    start_frame(4'b1011, 1'b1);
    in_valid = 1'b0;
    check_frame(4'b1011, 1'b1, 1'b0);
    @(negedge clk);
    check_idle("single_idle");

    // Back-to-back with in_valid held high
    accept_cyc.delete();
    start_frame(4'h0, 1'b0);
    check_frame(4'h0, 1'b0, 1'b0);
    data_in   = 4'hF;
    parity_in = 1'b0;
    @(negedge clk);
    check_idle("b2b_idle");
    @(negedge clk);
    in_valid = 1'b0;
    check_frame(4'hF, 1'b0, 1'b0);
    check("b2b_accepts", 32'(accept_cyc.size()), 32'd2);
    if (accept_cyc.size() == 2)
      check("b2b_period", 32'(accept_cyc[1] - accept_cyc[0]), 32'(FRAME_CYCLES + 1));
    @(negedge clk);
    check_idle("b2b_end");

    // Random frames; odd iterations hold in_valid and scramble the inputs
    for (int i = 0; i < 6; i++) begin
      d = 4'($urandom);
      p = 1'($urandom);
      start_frame(d, p);
      if (i % 2 == 0) in_valid = 1'b0;
      check_frame(d, p, (i % 2) == 1);
      in_valid = 1'b0;
      @(negedge clk);
      check_idle("rand_idle");
    end

    // Reset in the second DATA bit
    d = 4'($urandom);
    p = 1'($urandom);
    start_frame(d, p);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_bit1", 32'(tx), 32'(d[1]));
    rst = 1'b1;
    @(negedge clk);
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd0);
    check("abort_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check_idle("abort_idle");
    end
    d = 4'($urandom);
    p = 1'($urandom);
    start_frame(d, p);
    in_valid = 1'b0;
    check_frame(d, p, 1'b0);
    @(negedge clk);

    // Parity mismatch and match on the same nibble
    start_frame(4'b0111, 1'b0);
    in_valid = 1'b0;
    check_frame(4'b0111, 1'b0, 1'b0);
    @(negedge clk);
    start_frame(4'b0111, 1'b1);
    in_valid = 1'b0;
    check_frame(4'b0111, 1'b1, 1'b0);
    @(negedge clk);
    check_idle("final_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
